// File: rtl/vga_mem_arb.sv
// vga_mem_arb: single-port video memory arbiter, display reads take priority over a held host request.
// Ports: clk; rst_n (active-high synchronous reset despite the name);
//   display: d_req/d_addr in, d_gnt/d_rvalid/d_rdata out;
//   host: h_req/h_we/h_addr/h_wdata in, h_ack/h_rvalid/h_rdata out;
//   memory: m_addr/m_we/m_wdata out, m_rdata in; d_miss_cnt out.
// Optional starvation guard: define VGA_ARB_STARVE_GUARD_EN.
module vga_mem_arb #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int RD_LAT = 1,
  parameter int HOST_WAIT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [15:0]   d_miss_cnt
);
  // per-stage read tag {display read, host read}; last stage selects the rdata register to load
  logic [1:0] tag [RD_LAT];
  logic force_host;
`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(HOST_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [15:0] miss;
  assign force_host = state == FORCE;
  assign d_miss_cnt = miss;
  // the count includes the first blocked cycle so FORCE lands HOST_WAIT cycles after h_req rises
  always_comb begin
    wcnt_nx = h_ack || !h_req ? '0 : wcnt + 1'b1;
    state_nx = state == FORCE || h_ack || !h_req ? IDLE :
               state == WAIT && wcnt >= CW'(HOST_WAIT - 1) ? FORCE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      miss <= '0;
    end else begin
      state <= state_nx;
      wcnt <= wcnt_nx;
      if (force_host && d_req && !(&miss)) miss <= miss + 1'b1;
    end
  end
`else
  assign force_host = 1'b0;
  assign d_miss_cnt = '0;
`endif
  assign d_gnt = !rst_n && d_req && !force_host;
  assign h_ack = !rst_n && h_req && !d_gnt;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      m_addr <= '0;
      m_we <= 1'b0;
      m_wdata <= '0;
      d_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      d_rdata <= '0;
      h_rdata <= '0;
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
    end else begin
      m_addr <= d_gnt ? d_addr : h_ack ? h_addr : m_addr;
      m_we <= h_ack && h_we;
      if (h_ack && h_we) m_wdata <= h_wdata;
      tag[0] <= {d_gnt, h_ack && !h_we};
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
      d_rvalid <= tag[RD_LAT-1][1];
      h_rvalid <= tag[RD_LAT-1][0];
      if (tag[RD_LAT-1][1]) d_rdata <= m_rdata;
      if (tag[RD_LAT-1][0]) h_rdata <= m_rdata;
    end
  end
endmodule
